// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Package     : vga_timing_pkg
// Description : 640x480@60 raster timing constants shared by the VGA sync
//               generator and its axis counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  // Horizontal timing, in pixels
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;

  // Vertical timing, in lines
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  // Default counter / coordinate width
  localparam int unsigned VGA_CW = 10;

  // Length of one axis period (visible + porches + sync)
  function automatic int unsigned axis_total(
    input int unsigned visible,
    input int unsigned front,
    input int unsigned sync,
    input int unsigned back
  );
    return visible + front + sync + back;
  endfunction

  localparam int unsigned VGA_H_TOTAL =
    axis_total(VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
  localparam int unsigned VGA_V_TOTAL =
    axis_total(VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// Module      : vga_axis_counter
// Description : Enabled modulo-TOTAL counter for one raster axis. Exposes the
//               next count (so downstream registers can track the counter with
//               zero latency) and a flag marking the last position.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter #(
  parameter int unsigned TOTAL = 800,
  parameter int unsigned CW    = 10
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          en_i,
  output logic [CW-1:0] next_o,
  output logic          last_o
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: advance when enabled, wrapping from LAST back to zero
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  // Count register; reset parks on LAST so the first enable lands on zero
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LAST;
    end else begin
      count_q <= count_d;
    end
  end

  assign next_o = count_d;
  assign last_o = (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster timing generator. Advances one pixel per pix_en
//               strobe and drives sync, visible-area and coordinate outputs,
//               all registered from the next counter values so they always
//               agree with the current (h,v) position.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter logic        SYNC_POL  = 1'b0,
  parameter int unsigned CW        = VGA_CW
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  // Inclusive window bounds, kept inside CW bits so no compare can overflow
  localparam logic [CW-1:0] H_VIS_LAST = CW'(H_VISIBLE - 1);
  localparam logic [CW-1:0] V_VIS_LAST = CW'(V_VISIBLE - 1);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Both axis periods must fit in the counter width
  if (H_TOTAL > (64'd1 << CW)) begin : g_h_total_check
    $error("vga_sync_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (64'd1 << CW)) begin : g_v_total_check
    $error("vga_sync_gen: V_TOTAL does not fit in CW bits");
  end

  logic [CW-1:0] h_d;
  logic [CW-1:0] v_d;
  logic          h_last;
  logic          v_last;
  logic          v_en;

  // Vertical axis only steps on the strobe that wraps the horizontal axis
  assign v_en = pix_en & h_last;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .CW    (CW)
  ) u_h_counter (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en_i   (pix_en),
    .next_o (h_d),
    .last_o (h_last)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .CW    (CW)
  ) u_v_counter (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en_i   (v_en),
    .next_o (v_d),
    .last_o (v_last)
  );

  logic          hsync_q,       hsync_d;
  logic          vsync_q,       vsync_d;
  logic          video_on_q,    video_on_d;
  logic [CW-1:0] pixel_x_q,     pixel_x_d;
  logic [CW-1:0] pixel_y_q,     pixel_y_d;
  logic          line_start_q,  line_start_d;
  logic          frame_start_q, frame_start_d;

  // Decode outputs from the position the counters move to on this edge
  always_comb begin
    hsync_d       = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (h_d <= H_VIS_LAST) && (v_d <= V_VIS_LAST);
    pixel_x_d     = video_on_d ? h_d : '0;
    pixel_y_d     = video_on_d ? v_d : '0;
    line_start_d  = v_en;
    frame_start_d = v_en & v_last;
  end

  // Output registers; pulses self-clear because the wrap flag cannot repeat
  // on consecutive strobes
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Scoreboard bench for vga_sync_gen using a reduced raster
//               (32 x 19 total, 20 x 12 visible) so whole frames stay short.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

  localparam int HV = 20, HF = 3, HS = 5, HB = 4, HT = 32;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3, VT = 19;
  localparam int CW = 10;
  localparam int FRAME = HT * VT;  // 608 strobes

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic          pix_en = 1'b0;
  logic          hsync, vsync, video_on, line_start, frame_start;
  logic [CW-1:0] pixel_x, pixel_y;

  always #5 clk_in = ~clk_in;

  vga_sync_gen #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .SYNC_POL  (1'b0), .CW (CW)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          vid;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ls;
    logic          fs;
  } obs_t;

  typedef struct {
    obs_t o;
    logic strobe;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Counters gathered by the monitor over strobe cycles / all cycles
  int cnt_strobe, cnt_hlow, cnt_vlow, cnt_vid, cnt_ls, cnt_fs, cnt_badxy, cnt_ls_cyc;

  // Reference position
  int   mh = HT - 1;
  int   mv = VT - 1;
  logic mls = 1'b0;
  logic mfs = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.hs  = (mh >= HV + HF && mh < HV + HF + HS) ? 1'b0 : 1'b1;
    o.vs  = (mv >= VV + VF && mv < VV + VF + VS) ? 1'b0 : 1'b1;
    o.vid = (mh < HV) && (mv < VV);
    o.x   = o.vid ? CW'(mh) : '0;
    o.y   = o.vid ? CW'(mv) : '0;
    o.ls  = mls;
    o.fs  = mfs;
    return o;
  endfunction

  task automatic model_step(input logic en);
    if (!rst_n) begin
      mh = HT - 1; mv = VT - 1; mls = 1'b0; mfs = 1'b0;
    end else if (en) begin
      mls = (mh == HT - 1);
      mfs = mls && (mv == VT - 1);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end else begin
      mls = 1'b0; mfs = 1'b0;
    end
  endtask

  // One clock: drive pix_en, let the edge happen, queue the expected outputs
  task automatic step(input logic en);
    exp_t e;
    pix_en = en;
    @(posedge clk_in);
    #1;
    model_step(en);
    e.o      = model_obs();
    e.strobe = en && rst_n;
    sb_q.push_back(e);
  endtask

  // Wait until the monitor has consumed everything queued so far
  task automatic drain();
    @(negedge clk_in);
    #1;
  endtask

  task automatic clear_counts();
    cnt_strobe = 0; cnt_hlow = 0; cnt_vlow = 0; cnt_vid = 0;
    cnt_ls = 0; cnt_fs = 0; cnt_badxy = 0; cnt_ls_cyc = 0;
  endtask

  task automatic check_frame_counts(input string tag);
    check({tag, "_strobes"},   cnt_strobe, FRAME);
    check({tag, "_line_start"}, cnt_ls, VT);          // 19
    check({tag, "_ls_cycles"}, cnt_ls_cyc, VT);       // pulses exactly 1 cycle wide
    check({tag, "_frame_start"}, cnt_fs, 1);
    check({tag, "_hsync_low"}, cnt_hlow, HS * VT);    // 95
    check({tag, "_vsync_low"}, cnt_vlow, VS * HT);    // 64
    check({tag, "_video_on"},  cnt_vid, HV * VV);     // 240
    check({tag, "_xy_outside"}, cnt_badxy, 0);
  endtask

  // Monitor: compares every queued expectation against the DUT at negedge
  initial begin : monitor
    exp_t e;
    obs_t a;
    forever begin
      @(negedge clk_in);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start};
        check("cycle_outputs", 64'(a), 64'(e.o));
        if (line_start) cnt_ls_cyc++;
        if (e.strobe) begin
          cnt_strobe++;
          if (!hsync)     cnt_hlow++;
          if (!vsync)     cnt_vlow++;
          if (video_on)   cnt_vid++;
          if (line_start) cnt_ls++;
          if (frame_start) cnt_fs++;
          if (!video_on && (pixel_x != '0 || pixel_y != '0)) cnt_badxy++;
        end
      end
    end
  end

  initial begin : driver
    clear_counts();

    // Reset held for a few cycles
    repeat (3) step(1'b0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_video_on", video_on, 0);
    check("rst_pixel_xy", {pixel_x, pixel_y}, 0);
    check("rst_pulses", {line_start, frame_start}, 0);
    rst_n = 1'b1;
    drain();
    clear_counts();

    // Frame with a strobe every 4th cycle
    for (int k = 0; k < FRAME; k++) begin
      step(1'b1);
      if (k == 0) begin
        check("first_frame_start", frame_start, 1);
        check("first_line_start", line_start, 1);
        check("first_video_on", video_on, 1);
        check("first_xy", {pixel_x, pixel_y}, 0);
      end
      if (k == 19) check("last_visible_x", pixel_x, 19);
      if (k == 20) check("first_blank", {video_on, pixel_x}, 0);
      if (k == 22) check("pre_hsync", hsync, 1);
      if (k == 23) check("first_hsync_low", hsync, 0);
      if (k == 27) check("last_hsync_low", hsync, 0);
      if (k == 28) check("post_hsync", hsync, 1);
      step(1'b0);
      if (k == 0) check("pulse_cleared", {line_start, frame_start}, 0);
      step(1'b0);
      step(1'b0);
    end
    drain();
    check_frame_counts("div4");
    clear_counts();

    // Frame with pix_en tied high
    for (int k = 0; k < FRAME; k++) begin
      step(1'b1);
      if (k == 1) check("cont_pulse_cleared", {line_start, frame_start}, 0);
      if (k == HT * (VV + VF)) check("first_vsync_low", vsync, 0);
      if (k == HT * (VV + VF) - 1) check("pre_vsync", vsync, 1);
    end
    drain();
    check_frame_counts("cont");

    // Park inside horizontal sync at (25,0), then freeze for 50 cycles
    repeat (26) step(1'b1);
    check("park_hsync", hsync, 0);
    repeat (50) step(1'b0);
    check("frozen_hsync", hsync, 0);
    check("frozen_levels", {vsync, video_on, pixel_x, pixel_y}, {1'b1, 1'b0, 20'd0});
    check("frozen_pulses", {line_start, frame_start}, 0);

    // Move to (10,6) and reset asynchronously between edges with pix_en high
    repeat (177) step(1'b1);
    check("mid_xy", {video_on, pixel_x, pixel_y}, {1'b1, 10'd10, 10'd6});
    drain();
    pix_en = 1'b1;
    rst_n  = 1'b0;
    #1;
    check("async_rst_levels", {hsync, vsync, video_on}, 3'b110);
    check("async_rst_xy", {pixel_x, pixel_y}, 0);
    repeat (2) step(1'b1);
    rst_n = 1'b1;
    step(1'b0);
    step(1'b1);
    check("post_rst_frame_start", {frame_start, line_start}, 2'b11);
    check("post_rst_xy", {video_on, pixel_x, pixel_y}, {1'b1, 20'd0});
    repeat (5) step(1'b1);
    drain();
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
